// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings and control-bundle types for the pipelined MIPS control unit.
package pipe_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] FN_MULT  = 6'b011000;
   localparam logic [5:0] FN_DIV   = 6'b011010;
   localparam logic [5:0] FN_ADD   = 6'b100000;
   localparam logic [5:0] FN_SUB   = 6'b100010;
   localparam logic [5:0] FN_AND   = 6'b100100;
   localparam logic [5:0] FN_OR    = 6'b100101;
   localparam logic [5:0] FN_XOR   = 6'b100110;
   localparam logic [5:0] FN_NOR   = 6'b100111;
   localparam logic [5:0] FN_SLT   = 6'b101010;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_AND  = 4'b0010;
   localparam logic [3:0] ALU_OR   = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_NOR  = 4'b0101;
   localparam logic [3:0] ALU_MUL  = 4'b0110;
   localparam logic [3:0] ALU_DIV  = 4'b0111;
   localparam logic [3:0] ALU_SLT  = 4'b1001;

   typedef enum logic [1:0] {
      MD_NONE = 2'd0,
      MD_MUL  = 2'd1,
      MD_DIV  = 2'd2
   } md_kind_t;

   typedef struct packed {
      logic [3:0] alu_ctrl;
      logic       alu_src;
      logic       reg_dst;
      logic       branch;
      logic       branch_ne;
      logic       jump;
      logic       link;
      logic       zero_ext;
   } ex_ctrl_t;

   typedef struct packed {
      logic mem_write;
      logic mem_read;
   } mem_ctrl_t;

   typedef struct packed {
      logic reg_write;
      logic mem_to_reg;
      logic link;
   } wb_ctrl_t;

   typedef struct packed {
      ex_ctrl_t  ex;
      mem_ctrl_t mem;
      wb_ctrl_t  wb;
      logic      valid;
      logic      illegal;
   } ctrl_bundle_t;

   localparam ctrl_bundle_t BUBBLE     = '0;
   localparam mem_ctrl_t    MEM_BUBBLE = '0;
   localparam wb_ctrl_t     WB_BUBBLE  = '0;

endpackage

// File: rtl/pipe_ctrl_unit_decode.sv
// Combinational ID-stage decoder: op/Funct to control bundle, with parameter-gated
// extended and mult/div instructions reported as illegal when disabled.
module ctrl_decode
   import pipe_ctrl_pkg::*;
#(
   parameter int EN_EXT_OPS = 1,
   parameter int EN_MULDIV  = 1
) (
   input  logic [5:0]   op_i,
   input  logic [5:0]   funct_i,
   output ctrl_bundle_t bundle_o,
   output md_kind_t     md_o
);

   ctrl_bundle_t dec;
   md_kind_t     md;
   logic         legal;

   always_comb begin
      // NOTE: every variable gets a default before the case so no path infers a latch.
      dec              = BUBBLE;
      dec.valid        = 1'b1;
      dec.wb.reg_write = 1'b1;
      dec.ex.reg_dst   = 1'b1;
      dec.ex.alu_ctrl  = ALU_SUB;
      md               = MD_NONE;
      legal            = 1'b1;

      case (op_i)
         OP_RTYPE: begin
            case (funct_i)
               FN_ADD: dec.ex.alu_ctrl = ALU_ADD;
               FN_SUB: dec.ex.alu_ctrl = ALU_SUB;
               FN_AND: dec.ex.alu_ctrl = ALU_AND;
               FN_OR:  dec.ex.alu_ctrl = ALU_OR;
               FN_SLT: dec.ex.alu_ctrl = ALU_SLT;
               FN_XOR: if (EN_EXT_OPS != 0) dec.ex.alu_ctrl = ALU_XOR; else legal = 1'b0;
               FN_NOR: if (EN_EXT_OPS != 0) dec.ex.alu_ctrl = ALU_NOR; else legal = 1'b0;
               FN_MULT: begin
                  if (EN_MULDIV != 0) begin
                     dec.ex.alu_ctrl = ALU_MUL;
                     md              = MD_MUL;
                  end else legal = 1'b0;
               end
               FN_DIV: begin
                  if (EN_MULDIV != 0) begin
                     dec.ex.alu_ctrl = ALU_DIV;
                     md              = MD_DIV;
                  end else legal = 1'b0;
               end
               default: legal = 1'b0;
            endcase
         end
         OP_LW: begin
            dec.ex.reg_dst    = 1'b0;
            dec.ex.alu_src    = 1'b1;
            dec.ex.alu_ctrl   = ALU_ADD;
            dec.mem.mem_read  = 1'b1;
            dec.wb.mem_to_reg = 1'b1;
         end
         OP_SW: begin
            dec.ex.alu_src    = 1'b1;
            dec.ex.alu_ctrl   = ALU_ADD;
            dec.mem.mem_write = 1'b1;
            dec.wb.reg_write  = 1'b0;
         end
         OP_ADDI: begin
            dec.ex.reg_dst  = 1'b0;
            dec.ex.alu_src  = 1'b1;
            dec.ex.alu_ctrl = ALU_ADD;
         end
         OP_ANDI, OP_ORI: begin
            if (EN_EXT_OPS != 0) begin
               dec.ex.reg_dst  = 1'b0;
               dec.ex.alu_src  = 1'b1;
               dec.ex.zero_ext = 1'b1;
               dec.ex.alu_ctrl = (op_i == OP_ANDI) ? ALU_AND : ALU_OR;
            end else legal = 1'b0;
         end
         OP_SLTI: begin
            if (EN_EXT_OPS != 0) begin
               dec.ex.reg_dst  = 1'b0;
               dec.ex.alu_src  = 1'b1;
               dec.ex.alu_ctrl = ALU_SLT;
            end else legal = 1'b0;
         end
         OP_BEQ: begin
            dec.ex.branch    = 1'b1;
            dec.wb.reg_write = 1'b0;
         end
         OP_BNE: begin
            if (EN_EXT_OPS != 0) begin
               dec.ex.branch    = 1'b1;
               dec.ex.branch_ne = 1'b1;
               dec.wb.reg_write = 1'b0;
            end else legal = 1'b0;
         end
         OP_J: begin
            dec.ex.jump      = 1'b1;
            dec.wb.reg_write = 1'b0;
         end
         OP_JAL: begin
            // Link is carried to WB so r31 receives PC+8 there.
            if (EN_EXT_OPS != 0) begin
               dec.ex.jump = 1'b1;
               dec.ex.link = 1'b1;
               dec.wb.link = 1'b1;
            end else legal = 1'b0;
         end
         default: legal = 1'b0;
      endcase

      if (!legal) begin
         dec         = BUBBLE;
         dec.illegal = 1'b1;
         md          = MD_NONE;
      end
   end

   assign bundle_o = dec;
   assign md_o     = md;

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit: ID decode plus ID/EX, EX/MEM, MEM/WB control registers,
// stall/flush bubble insertion and a mult/div busy counter that freezes EX.
module pipe_ctrl_unit
   import pipe_ctrl_pkg::*;
#(
   parameter int ALU_CTRL_W = 4,
   parameter int EN_EXT_OPS = 1,
   parameter int EN_MULDIV  = 1,
   parameter int MUL_CYCLES = 4,
   parameter int DIV_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  id_valid,
   input  logic [5:0]            op,
   input  logic [5:0]            Funct,
   input  logic                  stall_in,
   input  logic                  flush_in,
   output logic [ALU_CTRL_W-1:0] ex_ALUControl,
   output logic                  ex_ALUSrc,
   output logic                  ex_RegDst,
   output logic                  ex_Branch,
   output logic                  ex_BranchNe,
   output logic                  ex_jump,
   output logic                  ex_link,
   output logic                  ex_ZeroExt,
   output logic                  ex_valid,
   output logic                  mem_MemWrite,
   output logic                  mem_MemRead,
   output logic                  wb_RegWrite,
   output logic                  wb_MemtoReg,
   output logic                  wb_link,
   output logic                  illegal_op,
   output logic                  stall_req
);

   localparam int CNT_MAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   ctrl_bundle_t     dec_bundle;
   md_kind_t         dec_md;
   ctrl_bundle_t     idex_q, idex_d;
   mem_ctrl_t        exmem_mem_q, exmem_mem_d;
   wb_ctrl_t         exmem_wb_q, exmem_wb_d;
   wb_ctrl_t         memwb_q, memwb_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy;
   logic             load_new;

   ctrl_decode #(
      .EN_EXT_OPS (EN_EXT_OPS),
      .EN_MULDIV  (EN_MULDIV)
   ) u_decode (
      .op_i     (op),
      .funct_i  (Funct),
      .bundle_o (dec_bundle),
      .md_o     (dec_md)
   );

   assign busy     = (EN_MULDIV != 0) && (cnt_q != '0);
   assign load_new = id_valid && !flush_in && !stall_in;

   always_comb begin
      idex_d      = idex_q;
      exmem_mem_d = idex_q.mem;
      exmem_wb_d  = idex_q.wb;
      memwb_d     = exmem_wb_q;
      cnt_d       = cnt_q;

      if (busy) begin
         // EX is frozen; upstream re-presents any stall/flush once the counter drains.
         cnt_d       = cnt_q - CNT_W'(1);
         exmem_mem_d = MEM_BUBBLE;
         exmem_wb_d  = WB_BUBBLE;
      end else begin
         idex_d = load_new ? dec_bundle : BUBBLE;
         if (load_new && (EN_MULDIV != 0)) begin
            case (dec_md)
               MD_MUL:  cnt_d = CNT_W'(MUL_CYCLES - 1);
               MD_DIV:  cnt_d = CNT_W'(DIV_CYCLES - 1);
               default: cnt_d = '0;
            endcase
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every stage samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         idex_q      <= BUBBLE;
         exmem_mem_q <= MEM_BUBBLE;
         exmem_wb_q  <= WB_BUBBLE;
         memwb_q     <= WB_BUBBLE;
         cnt_q       <= '0;
      end else begin
         idex_q      <= idex_d;
         exmem_mem_q <= exmem_mem_d;
         exmem_wb_q  <= exmem_wb_d;
         memwb_q     <= memwb_d;
         cnt_q       <= cnt_d;
      end
   end

   assign ex_ALUControl = ALU_CTRL_W'(idex_q.ex.alu_ctrl);
   assign ex_ALUSrc     = idex_q.ex.alu_src;
   assign ex_RegDst     = idex_q.ex.reg_dst;
   assign ex_Branch     = idex_q.ex.branch;
   assign ex_BranchNe   = idex_q.ex.branch_ne;
   assign ex_jump       = idex_q.ex.jump;
   assign ex_link       = idex_q.ex.link;
   assign ex_ZeroExt    = idex_q.ex.zero_ext;
   assign ex_valid      = idex_q.valid;
   assign illegal_op    = idex_q.illegal;
   assign mem_MemWrite  = exmem_mem_q.mem_write;
   assign mem_MemRead   = exmem_mem_q.mem_read;
   assign wb_RegWrite   = memwb_q.reg_write;
   assign wb_MemtoReg   = memwb_q.mem_to_reg;
   assign wb_link       = memwb_q.link;
   assign stall_req     = busy;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit: full-featured instance plus a core-only instance.
module tb_pipe_ctrl_unit;

   logic       clk = 1'b0;
   logic       reset, id_valid, stall_in, flush_in;
   logic [5:0] op, Funct;

   logic [3:0] ex_ALUControl;
   logic ex_ALUSrc, ex_RegDst, ex_Branch, ex_BranchNe, ex_jump, ex_link, ex_ZeroExt, ex_valid;
   logic mem_MemWrite, mem_MemRead, wb_RegWrite, wb_MemtoReg, wb_link, illegal_op, stall_req;

   logic [3:0] n_ALUControl;
   logic n_ALUSrc, n_RegDst, n_Branch, n_BranchNe, n_jump, n_link, n_ZeroExt, n_valid;
   logic n_MemWrite, n_MemRead, n_RegWrite, n_MemtoReg, n_wb_link, n_illegal_op, n_stall_req;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pipe_ctrl_unit #(.ALU_CTRL_W(4), .EN_EXT_OPS(1), .EN_MULDIV(1),
                    .MUL_CYCLES(4), .DIV_CYCLES(16)) u_dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .op(op), .Funct(Funct),
      .stall_in(stall_in), .flush_in(flush_in),
      .ex_ALUControl(ex_ALUControl), .ex_ALUSrc(ex_ALUSrc), .ex_RegDst(ex_RegDst),
      .ex_Branch(ex_Branch), .ex_BranchNe(ex_BranchNe), .ex_jump(ex_jump),
      .ex_link(ex_link), .ex_ZeroExt(ex_ZeroExt), .ex_valid(ex_valid),
      .mem_MemWrite(mem_MemWrite), .mem_MemRead(mem_MemRead),
      .wb_RegWrite(wb_RegWrite), .wb_MemtoReg(wb_MemtoReg), .wb_link(wb_link),
      .illegal_op(illegal_op), .stall_req(stall_req)
   );

   pipe_ctrl_unit #(.ALU_CTRL_W(4), .EN_EXT_OPS(0), .EN_MULDIV(0),
                    .MUL_CYCLES(4), .DIV_CYCLES(16)) u_core (
      .clk(clk), .reset(reset), .id_valid(id_valid), .op(op), .Funct(Funct),
      .stall_in(stall_in), .flush_in(flush_in),
      .ex_ALUControl(n_ALUControl), .ex_ALUSrc(n_ALUSrc), .ex_RegDst(n_RegDst),
      .ex_Branch(n_Branch), .ex_BranchNe(n_BranchNe), .ex_jump(n_jump),
      .ex_link(n_link), .ex_ZeroExt(n_ZeroExt), .ex_valid(n_valid),
      .mem_MemWrite(n_MemWrite), .mem_MemRead(n_MemRead),
      .wb_RegWrite(n_RegWrite), .wb_MemtoReg(n_MemtoReg), .wb_link(n_wb_link),
      .illegal_op(n_illegal_op), .stall_req(n_stall_req)
   );

   // ex_vec = {ALUControl, ALUSrc, RegDst, Branch, BranchNe, jump, link, ZeroExt, valid}
   wire [11:0] ex_vec  = {ex_ALUControl, ex_ALUSrc, ex_RegDst, ex_Branch, ex_BranchNe,
                          ex_jump, ex_link, ex_ZeroExt, ex_valid};
   wire [1:0]  mem_vec = {mem_MemWrite, mem_MemRead};
   wire [2:0]  wb_vec  = {wb_RegWrite, wb_MemtoReg, wb_link};

   localparam logic [11:0] EX_ADD  = 12'b0000_0100_0001;
   localparam logic [11:0] EX_LW   = 12'b0000_1000_0001;
   localparam logic [11:0] EX_SW   = 12'b0000_1100_0001;
   localparam logic [11:0] EX_BEQ  = 12'b0001_0110_0001;
   localparam logic [11:0] EX_BNE  = 12'b0001_0111_0001;
   localparam logic [11:0] EX_JAL  = 12'b0001_0100_1101;
   localparam logic [11:0] EX_MULT = 12'b0110_0100_0001;
   localparam logic [11:0] EX_DIV  = 12'b0111_0100_0001;

   localparam logic [5:0] O_R = 6'b000000, O_LW = 6'b100011, O_SW = 6'b101011;
   localparam logic [5:0] O_BEQ = 6'b000100, O_BNE = 6'b000101, O_JAL = 6'b000011;
   localparam logic [5:0] O_ADDI = 6'b001000, O_ANDI = 6'b001100, O_BAD = 6'b111111;
   localparam logic [5:0] F_ADD = 6'b100000, F_MULT = 6'b011000, F_DIV = 6'b011010;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [5:0] o, input logic [5:0] f);
      id_valid = v;
      op       = o;
      Funct    = f;
   endtask

   task automatic drain();
      drive(1'b0, 6'd0, 6'd0);
      stall_in = 1'b0;
      flush_in = 1'b0;
      repeat (4) step();
   endtask

   task automatic test_reset();
      reset = 1'b1; stall_in = 1'b0; flush_in = 1'b0;
      drive(1'b1, O_R, F_ADD);
      step(); step();
      checks++;
      if ({ex_vec, mem_vec, wb_vec, illegal_op, stall_req} !== 19'd0) begin
         errors++;
         $display("FAIL reset_outputs: got %h expected 0",
                  {ex_vec, mem_vec, wb_vec, illegal_op, stall_req});
      end
      reset = 1'b0;
      step();
      checks++;
      if (ex_vec !== EX_ADD) begin
         errors++; $display("FAIL add_ex: got %h expected %h", ex_vec, EX_ADD);
      end
      drive(1'b0, 6'd0, 6'd0);
      step(); step();
      checks++;
      if (wb_vec !== 3'b100) begin
         errors++; $display("FAIL add_wb: got %b expected 100", wb_vec);
      end
   endtask

   task automatic test_back_to_back();
      logic [5:0]  ops [5];
      logic [11:0] ex_e [5];
      logic [1:0]  mem_e [5];
      logic [2:0]  wb_e [5];
      logic [11:0] x_exp;
      logic [1:0]  m_exp;
      logic [2:0]  w_exp;
      ops   = '{O_LW, O_SW, O_BEQ, O_BNE, O_JAL};
      ex_e  = '{EX_LW, EX_SW, EX_BEQ, EX_BNE, EX_JAL};
      mem_e = '{2'b01, 2'b10, 2'b00, 2'b00, 2'b00};
      wb_e  = '{3'b110, 3'b000, 3'b000, 3'b000, 3'b101};
      drain();
      drive(1'b1, ops[0], 6'd0);
      for (int c = 1; c <= 7; c++) begin
         step();
         if (c < 5) drive(1'b1, ops[c], 6'd0);
         else       drive(1'b0, 6'd0, 6'd0);
         x_exp = (c - 1 < 5) ? ex_e[c-1] : 12'd0;
         m_exp = (c >= 2 && c - 2 < 5) ? mem_e[c-2] : 2'd0;
         w_exp = (c >= 3) ? wb_e[c-3] : 3'd0;
         checks++;
         if (ex_vec !== x_exp) begin
            errors++; $display("FAIL b2b_ex c=%0d: got %h expected %h", c, ex_vec, x_exp);
         end
         checks++;
         if (mem_vec !== m_exp) begin
            errors++; $display("FAIL b2b_mem c=%0d: got %b expected %b", c, mem_vec, m_exp);
         end
         checks++;
         if (wb_vec !== w_exp) begin
            errors++; $display("FAIL b2b_wb c=%0d: got %b expected %b", c, wb_vec, w_exp);
         end
      end
   endtask

   task automatic test_stall();
      drain();
      drive(1'b1, O_R, F_ADD);
      step();
      drive(1'b1, O_LW, 6'd0);
      stall_in = 1'b1;
      step();
      checks++;
      if (ex_vec !== 12'd0) begin
         errors++; $display("FAIL stall_bubble: got %h expected 000", ex_vec);
      end
      stall_in = 1'b0;
      step();
      checks++;
      if (ex_vec !== EX_LW) begin
         errors++; $display("FAIL stall_lw_ex: got %h expected %h", ex_vec, EX_LW);
      end
      checks++;
      if (wb_vec !== 3'b100) begin
         errors++; $display("FAIL stall_prior_wb: got %b expected 100", wb_vec);
      end
      drive(1'b0, 6'd0, 6'd0);
      step();
      checks++;
      if (mem_vec !== 2'b01) begin
         errors++; $display("FAIL stall_lw_mem: got %b expected 01", mem_vec);
      end
   endtask

   task automatic test_flush();
      drain();
      drive(1'b1, O_ADDI, 6'd0);
      flush_in = 1'b1;
      step();
      checks++;
      if (ex_vec !== 12'd0) begin
         errors++; $display("FAIL flush_ex: got %h expected 000", ex_vec);
      end
      flush_in = 1'b0;
      drive(1'b0, 6'd0, 6'd0);
      step(); step();
      checks++;
      if (wb_vec !== 3'b000) begin
         errors++; $display("FAIL flush_wb: got %b expected 000", wb_vec);
      end
   endtask

   task automatic test_muldiv();
      logic        s_exp;
      logic [11:0] x_exp;
      logic [2:0]  w_exp;
      drain();
      drive(1'b1, O_R, F_MULT);
      for (int c = 1; c <= 6; c++) begin
         step();
         if (c == 1) begin
            drive(1'b1, O_R, F_ADD);
            flush_in = 1'b1;
            checks++;
            if (n_illegal_op !== 1'b1 || n_stall_req !== 1'b0) begin
               errors++;
               $display("FAIL core_mult: got illegal=%b stall=%b expected illegal=1 stall=0",
                        n_illegal_op, n_stall_req);
            end
         end
         s_exp = (c <= 3);
         x_exp = (c <= 4) ? EX_MULT : 12'd0;
         w_exp = (c == 6) ? 3'b100 : 3'b000;
         checks++;
         if (stall_req !== s_exp) begin
            errors++; $display("FAIL mul_stall c=%0d: got %b expected %b", c, stall_req, s_exp);
         end
         checks++;
         if (ex_vec !== x_exp) begin
            errors++; $display("FAIL mul_ex c=%0d: got %h expected %h", c, ex_vec, x_exp);
         end
         checks++;
         if (wb_vec !== w_exp) begin
            errors++; $display("FAIL mul_wb c=%0d: got %b expected %b", c, wb_vec, w_exp);
         end
      end
      flush_in = 1'b0;
      drive(1'b0, 6'd0, 6'd0);
   endtask

   task automatic test_illegal();
      drain();
      drive(1'b1, O_BAD, 6'd0);
      step();
      checks++;
      if (illegal_op !== 1'b1 || ex_vec !== 12'd0) begin
         errors++;
         $display("FAIL illegal_ex: got illegal=%b ex=%h expected illegal=1 ex=000", illegal_op, ex_vec);
      end
      drive(1'b0, O_BAD, 6'd0);
      step();
      checks++;
      if (illegal_op !== 1'b0 || mem_vec !== 2'b00) begin
         errors++;
         $display("FAIL illegal_pulse: got illegal=%b mem=%b expected illegal=0 mem=00", illegal_op, mem_vec);
      end
      step();
      checks++;
      if (wb_vec !== 3'b000) begin
         errors++; $display("FAIL illegal_wb: got %b expected 000", wb_vec);
      end
   endtask

   task automatic test_ext_disabled();
      drain();
      drive(1'b1, O_ANDI, 6'd0);
      step();
      checks++;
      if (n_illegal_op !== 1'b1 || n_valid !== 1'b0) begin
         errors++;
         $display("FAIL core_andi: got illegal=%b valid=%b expected illegal=1 valid=0", n_illegal_op, n_valid);
      end
      checks++;
      if (illegal_op !== 1'b0 || ex_vec[7:0] !== 8'b1000_0011) begin
         errors++;
         $display("FAIL ext_andi: got illegal=%b ex_lo=%b expected illegal=0 ex_lo=10000011",
                  illegal_op, ex_vec[7:0]);
      end
      drive(1'b0, 6'd0, 6'd0);
   endtask

   task automatic test_reset_mid_div();
      drain();
      drive(1'b1, O_R, F_DIV);
      step();
      drive(1'b0, 6'd0, 6'd0);
      repeat (6) step();
      checks++;
      if (stall_req !== 1'b1 || ex_vec !== EX_DIV) begin
         errors++;
         $display("FAIL div_busy: got stall=%b ex=%h expected stall=1 ex=%h", stall_req, ex_vec, EX_DIV);
      end
      reset = 1'b1;
      step();
      checks++;
      if ({ex_vec, mem_vec, wb_vec, illegal_op, stall_req} !== 19'd0) begin
         errors++;
         $display("FAIL div_reset: got %h expected 0", {ex_vec, mem_vec, wb_vec, illegal_op, stall_req});
      end
      reset = 1'b0;
      step();
      checks++;
      if (stall_req !== 1'b0) begin
         errors++; $display("FAIL div_abort: got stall=%b expected 0", stall_req);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_back_to_back();
      test_stall();
      test_flush();
      test_muldiv();
      test_illegal();
      test_ext_disabled();
      test_reset_mid_div();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
